// File: rtl/nc_fetch_bridge.sv
// rtl/nc_fetch_bridge.sv - non-cacheable icache line fetch bridge: one memory burst per request
// Optional watchdog enabled by defining NC_FETCH_TIMEOUT_EN.
module nc_fetch_bridge #(
  parameter int LINE_W         = 128,
  parameter int BEAT_W         = 32,
  parameter int ADDR_W         = 40,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              nc_req_valid_i,
  input  logic [ADDR_W-1:0] nc_req_addr_i,
  output logic              nc_resp_valid_o,
  output logic [LINE_W-1:0] nc_resp_data_o,
  output logic              nc_resp_err_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  input  logic              mem_rsp_valid_i,
  input  logic [BEAT_W-1:0] mem_rsp_data_i,
  input  logic              mem_rsp_last_i,
  input  logic              mem_rsp_err_i,
  output logic              busy_o
);

  localparam int NBEATS = LINE_W / BEAT_W;
  localparam int CNT_W  = $clog2(NBEATS);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NBEATS - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_W / 8 - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_BEATS, S_RESP, S_DRAIN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [LINE_W-1:0] resp_data_q, resp_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              flush_rec_q, flush_rec_d;
  logic              drain_resp_q, drain_resp_d;
  logic              resp_valid, resp_err;
  logic              drain_ok;
  logic              beat_last;
  logic              at_last;
  int                slot;

`ifdef NC_FETCH_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            req_pend_q, req_pend_d;
  logic            wd_fire;
  assign wd_fire  = (wd_q == WD_LIM);
  // A timed-out request stays on the bus until the handshake; beats before it are strays.
  assign drain_ok = !req_pend_q;
  assign mem_req_valid_o = (state_q == S_REQ) || (state_q == S_DRAIN && req_pend_q);
`else
  assign drain_ok = 1'b1;
  assign mem_req_valid_o = (state_q == S_REQ);
`endif

  assign beat_last = mem_rsp_valid_i && mem_rsp_last_i;
  assign at_last   = (cnt_q == LAST_CNT);
  assign slot      = int'(cnt_q) * BEAT_W;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    line_d       = line_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    flush_rec_d  = flush_rec_q;
    drain_resp_d = drain_resp_q;
    resp_valid   = 1'b0;
    resp_err     = 1'b0;
`ifdef NC_FETCH_TIMEOUT_EN
    req_pend_d   = req_pend_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (nc_req_valid_i && !flush_i) begin
          addr_d      = nc_req_addr_i & ~OFF_MASK;
          flush_rec_d = 1'b0;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (flush_i) flush_rec_d = 1'b1;
        if (mem_req_ready_i) begin
          state_d      = (flush_rec_q || flush_i) ? S_DRAIN : S_BEATS;
          cnt_d        = '0;
          err_d        = 1'b0;
          flush_rec_d  = 1'b0;
          drain_resp_d = 1'b0;
        end
`ifdef NC_FETCH_TIMEOUT_EN
        else if (wd_fire) begin
          resp_valid   = !flush_i;
          resp_err     = 1'b1;
          req_pend_d   = 1'b1;
          flush_rec_d  = 1'b0;
          drain_resp_d = 1'b0;
          state_d      = S_DRAIN;
        end
`endif
      end
      S_BEATS: begin
        if (mem_rsp_valid_i) begin
          line_d[slot +: BEAT_W] = mem_rsp_data_i;
          cnt_d = cnt_q + 1'b1;
          if (mem_rsp_err_i || (mem_rsp_last_i != at_last)) err_d = 1'b1;
        end
        if (flush_i) begin
          state_d      = beat_last ? S_IDLE : S_DRAIN;
          drain_resp_d = 1'b0;
        end else if (beat_last) begin
          state_d = S_RESP;
        end else if (mem_rsp_valid_i && at_last) begin
          // Burst overran the line: respond with error once the memory finishes it.
          state_d      = S_DRAIN;
          drain_resp_d = 1'b1;
        end
`ifdef NC_FETCH_TIMEOUT_EN
        else if (wd_fire && !mem_rsp_valid_i) begin
          resp_valid   = 1'b1;
          resp_err     = 1'b1;
          drain_resp_d = 1'b0;
          state_d      = S_DRAIN;
        end
`endif
      end
      S_RESP: begin
        resp_valid = !flush_i;
        resp_err   = err_q;
        state_d    = S_IDLE;
      end
      S_DRAIN: begin
        if (flush_i) drain_resp_d = 1'b0;
`ifdef NC_FETCH_TIMEOUT_EN
        if (req_pend_q && mem_req_ready_i) req_pend_d = 1'b0;
`endif
        if (drain_ok && beat_last) begin
          state_d = (drain_resp_q && !flush_i) ? S_RESP : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    resp_data_d = (state_d == S_RESP && state_q != S_RESP) ? line_d : resp_data_q;
`ifdef NC_FETCH_TIMEOUT_EN
    wd_d = (state_d != state_q || mem_rsp_valid_i) ? '0 : wd_q + 1'b1;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      line_q       <= '0;
      resp_data_q  <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      flush_rec_q  <= 1'b0;
      drain_resp_q <= 1'b0;
`ifdef NC_FETCH_TIMEOUT_EN
      wd_q         <= '0;
      req_pend_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      line_q       <= line_d;
      resp_data_q  <= resp_data_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      flush_rec_q  <= flush_rec_d;
      drain_resp_q <= drain_resp_d;
`ifdef NC_FETCH_TIMEOUT_EN
      wd_q         <= wd_d;
      req_pend_q   <= req_pend_d;
`endif
    end
  end

  assign nc_resp_valid_o = resp_valid;
  assign nc_resp_err_o   = resp_valid && resp_err;
  assign nc_resp_data_o  = resp_data_q;
  assign mem_req_addr_o  = addr_q;
  assign busy_o          = (state_q != S_IDLE);

endmodule

// File: tb/tb_nc_fetch_bridge.sv
// tb/tb_nc_fetch_bridge.sv - directed self-checking bench for nc_fetch_bridge
module tb_nc_fetch_bridge;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         req_valid = 1'b0;
  logic [39:0]  req_addr = '0;
  logic         resp_valid;
  logic [127:0] resp_data;
  logic         resp_err;
  logic         mreq_valid;
  logic         mreq_ready = 1'b0;
  logic [39:0]  mreq_addr;
  logic         rsp_valid = 1'b0;
  logic [31:0]  rsp_data = '0;
  logic         rsp_last = 1'b0;
  logic         rsp_err = 1'b0;
  logic         busy;

  int n_checks = 0;
  int n_pass = 0;
  int resp_count = 0;
  int hs_count = 0;

  nc_fetch_bridge #(.LINE_W(128), .BEAT_W(32), .ADDR_W(40), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .nc_req_valid_i(req_valid), .nc_req_addr_i(req_addr),
    .nc_resp_valid_o(resp_valid), .nc_resp_data_o(resp_data), .nc_resp_err_o(resp_err),
    .mem_req_valid_o(mreq_valid), .mem_req_ready_i(mreq_ready), .mem_req_addr_o(mreq_addr),
    .mem_rsp_valid_i(rsp_valid), .mem_rsp_data_i(rsp_data), .mem_rsp_last_i(rsp_last),
    .mem_rsp_err_i(rsp_err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (resp_valid) resp_count++;
    if (mreq_valid && mreq_ready) hs_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_fetch(input logic [39:0] addr);
    req_valid = 1'b1;
    req_addr  = addr;
    tick();
    req_valid  = 1'b0;
    mreq_ready = 1'b1;
    tick();
    mreq_ready = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last, input logic err);
    rsp_valid = 1'b1;
    rsp_data  = d;
    rsp_last  = last;
    rsp_err   = err;
    tick();
    rsp_valid = 1'b0;
    rsp_last  = 1'b0;
    rsp_err   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (mreq_valid !== 1'b0) $display("FAIL reset_mreq_valid: got %b expected 0", mreq_valid); else n_pass++;
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); else n_pass++;
    n_checks++; if (resp_data !== 128'h0) $display("FAIL reset_resp_data: got %h expected 0", resp_data); else n_pass++;
    n_checks++; if (mreq_addr !== 40'h0) $display("FAIL reset_mreq_addr: got %h expected 0", mreq_addr); else n_pass++;
  endtask

  task automatic test_basic();
    req_valid = 1'b1;
    req_addr  = 40'h80001234;
    tick();
    req_valid = 1'b0;
    n_checks++; if (mreq_valid !== 1'b1) $display("FAIL basic_mreq_valid: got %b expected 1", mreq_valid); else n_pass++;
    n_checks++; if (mreq_addr !== 40'h80001230) $display("FAIL basic_mreq_addr: got %h expected 80001230", mreq_addr); else n_pass++;
    mreq_ready = 1'b1;
    tick();
    mreq_ready = 1'b0;
    send_beat(32'h11111111, 1'b0, 1'b0);
    req_valid = 1'b1;
    req_addr  = 40'h55555555;
    send_beat(32'h22222222, 1'b0, 1'b0);
    req_valid = 1'b0;
    send_beat(32'h33333333, 1'b0, 1'b0);
    send_beat(32'h44444444, 1'b1, 1'b0);
    n_checks++; if (resp_valid !== 1'b1) $display("FAIL basic_resp_valid: got %b expected 1", resp_valid); else n_pass++;
    n_checks++; if (resp_data !== 128'h44444444_33333333_22222222_11111111) $display("FAIL basic_resp_data: got %h expected 44444444333333332222222211111111", resp_data); else n_pass++;
    n_checks++; if (resp_err !== 1'b0) $display("FAIL basic_resp_err: got %b expected 0", resp_err); else n_pass++;
    tick();
    n_checks++; if (busy !== 1'b0 || resp_valid !== 1'b0) $display("FAIL basic_idle_after: busy %b valid %b expected 0 0", busy, resp_valid); else n_pass++;
    n_checks++; if (resp_data !== 128'h44444444_33333333_22222222_11111111) $display("FAIL basic_data_hold: got %h expected 44444444333333332222222211111111", resp_data); else n_pass++;
  endtask

  task automatic test_idle_flush();
    req_valid = 1'b1;
    req_addr  = 40'h1000;
    flush     = 1'b1;
    tick();
    req_valid = 1'b0;
    flush     = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL idle_flush_req: busy %b expected 0", busy); else n_pass++;
  endtask

  task automatic test_ready_stall();
    int hs0;
    logic stable;
    hs0 = hs_count;
    stable = 1'b1;
    req_valid = 1'b1;
    req_addr  = 40'h12345678;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (mreq_valid !== 1'b1 || mreq_addr !== 40'h12345670) stable = 1'b0;
      tick();
    end
    n_checks++; if (stable !== 1'b1) $display("FAIL stall_stable: valid %b addr %h expected 1 12345670", mreq_valid, mreq_addr); else n_pass++;
    mreq_ready = 1'b1;
    tick();
    mreq_ready = 1'b0;
    n_checks++; if (hs_count - hs0 !== 1) $display("FAIL stall_handshakes: got %0d expected 1", hs_count - hs0); else n_pass++;
    n_checks++; if (mreq_valid !== 1'b0) $display("FAIL stall_req_drop: got %b expected 0", mreq_valid); else n_pass++;
    send_beat(32'hA0, 1'b0, 1'b0);
    send_beat(32'hA1, 1'b0, 1'b0);
    send_beat(32'hA2, 1'b0, 1'b0);
    send_beat(32'hA3, 1'b1, 1'b0);
    n_checks++; if (resp_data !== {32'hA3, 32'hA2, 32'hA1, 32'hA0}) $display("FAIL stall_data: got %h expected a3/a2/a1/a0", resp_data); else n_pass++;
    tick();
  endtask

  task automatic test_err_beat();
    int rc0;
    rc0 = resp_count;
    start_fetch(40'h2000);
    send_beat(32'h1, 1'b0, 1'b0);
    send_beat(32'h2, 1'b0, 1'b1);
    send_beat(32'h3, 1'b0, 1'b0);
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL err_no_early_resp: got %b expected 0", resp_valid); else n_pass++;
    send_beat(32'h4, 1'b1, 1'b0);
    n_checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) $display("FAIL err_resp: valid %b err %b expected 1 1", resp_valid, resp_err); else n_pass++;
    tick();
    n_checks++; if (resp_count - rc0 !== 1) $display("FAIL err_single_resp: got %0d expected 1", resp_count - rc0); else n_pass++;
  endtask

  task automatic test_flush_beats();
    int rc0;
    rc0 = resp_count;
    start_fetch(40'h3000);
    send_beat(32'hB0, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (busy !== 1'b1) $display("FAIL flush_draining_busy: got %b expected 1", busy); else n_pass++;
    send_beat(32'hB1, 1'b0, 1'b0);
    send_beat(32'hB2, 1'b0, 1'b0);
    send_beat(32'hB3, 1'b1, 1'b0);
    n_checks++; if (busy !== 1'b0) $display("FAIL flush_drained_idle: got %b expected 0", busy); else n_pass++;
    tick();
    n_checks++; if (resp_count !== rc0) $display("FAIL flush_no_resp: got %0d pulses expected 0", resp_count - rc0); else n_pass++;
    start_fetch(40'h3040);
    send_beat(32'hC0, 1'b0, 1'b0);
    send_beat(32'hC1, 1'b0, 1'b0);
    send_beat(32'hC2, 1'b0, 1'b0);
    send_beat(32'hC3, 1'b1, 1'b0);
    n_checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_data !== {32'hC3, 32'hC2, 32'hC1, 32'hC0}) $display("FAIL flush_refetch: valid %b err %b data %h expected 1 0 c3/c2/c1/c0", resp_valid, resp_err, resp_data); else n_pass++;
    tick();
  endtask

  task automatic test_early_last();
    start_fetch(40'h4000);
    send_beat(32'hDEADBEEF, 1'b1, 1'b0);
    n_checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) $display("FAIL early_last_resp: valid %b err %b expected 1 1", resp_valid, resp_err); else n_pass++;
    n_checks++; if (resp_data[31:0] !== 32'hDEADBEEF) $display("FAIL early_last_data: got %h expected deadbeef", resp_data[31:0]); else n_pass++;
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL early_last_idle: got %b expected 0", busy); else n_pass++;
  endtask

  task automatic test_late_last();
    start_fetch(40'h5000);
    send_beat(32'h01, 1'b0, 1'b0);
    send_beat(32'h02, 1'b0, 1'b0);
    send_beat(32'h03, 1'b0, 1'b0);
    send_beat(32'h04, 1'b0, 1'b0);
    n_checks++; if (resp_valid !== 1'b0 || busy !== 1'b1) $display("FAIL late_last_drain: valid %b busy %b expected 0 1", resp_valid, busy); else n_pass++;
    send_beat(32'hFF, 1'b1, 1'b0);
    n_checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_data !== {32'h04, 32'h03, 32'h02, 32'h01}) $display("FAIL late_last_resp: valid %b err %b data %h expected 1 1 04/03/02/01", resp_valid, resp_err, resp_data); else n_pass++;
    tick();
  endtask

  task automatic test_flush_resp();
    start_fetch(40'h6000);
    send_beat(32'hE0, 1'b0, 1'b0);
    send_beat(32'hE1, 1'b0, 1'b0);
    send_beat(32'hE2, 1'b0, 1'b0);
    send_beat(32'hE3, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL flush_resp_suppress: got %b expected 0", resp_valid); else n_pass++;
    tick();
    flush = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL flush_resp_idle: got %b expected 0", busy); else n_pass++;
  endtask

`ifdef NC_FETCH_TIMEOUT_EN
  task automatic test_timeout();
    int rc0;
    bit seen;
    rc0 = resp_count;
    seen = 1'b0;
    start_fetch(40'h7000);
    for (int i = 0; i < 40 && !seen; i++) begin
      if (resp_valid === 1'b1) begin
        seen = 1'b1;
        n_checks++; if (resp_err !== 1'b1) $display("FAIL timeout_err: got %b expected 1", resp_err); else n_pass++;
      end else tick();
    end
    n_checks++; if (seen !== 1'b1) $display("FAIL timeout_pulse: no response within 40 cycles"); else n_pass++;
    tick();
    send_beat(32'h70, 1'b0, 1'b0);
    send_beat(32'h71, 1'b0, 1'b0);
    send_beat(32'h72, 1'b0, 1'b0);
    send_beat(32'h73, 1'b1, 1'b0);
    tick();
    n_checks++; if (resp_count - rc0 !== 1 || busy !== 1'b0) $display("FAIL timeout_drain: pulses %0d busy %b expected 1 0", resp_count - rc0, busy); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_idle_flush();
    test_ready_stall();
    test_err_beat();
    test_flush_beats();
    test_early_last();
    test_late_last();
    test_flush_resp();
`ifdef NC_FETCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end
endmodule
